// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit
// Brief   : Resolves EX-stage branches/JAL/JALR from ALU flags, registers a PC
//           redirect and link value, then drives a multi-cycle front-end flush.
//           Optional macro BRANCH_STATS_EN adds branch count/taken counters.
// Revision: 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int N            = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_valid,
  input  logic         is_branch,
  input  logic         is_jal,
  input  logic         is_jalr,
  input  logic [2:0]   funct3,
  input  logic         cf,
  input  logic         zf,
  input  logic         vf,
  input  logic         sf,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] alu_result,
  output logic         redirect_o,
  output logic [N-1:0] redirect_pc_o,
  output logic [N-1:0] link_o,
  output logic         flush_o,
  output logic         misalign_o,
  output logic         illegal_o,
  output logic [31:0]  br_count_o,
  output logic [31:0]  br_taken_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]   C_CNT_INIT  = 4'(FLUSH_CYCLES - 1);
  localparam logic [N-1:0] C_JALR_MASK = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0] C_LINK_OFS  = N'(4);

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic         w_is_jal, w_is_br, w_accept;
  logic         w_cond, w_f3_illegal, w_taken, w_aligned, w_redirect;
  logic [N-1:0] w_target;
  logic         r_redirect, r_misalign, r_illegal;
  logic [N-1:0] r_redirect_pc, r_link;

  // Resolve overlapping type flags: JALR beats JAL beats branch.
  assign w_is_jal = is_jal & ~is_jalr;
  assign w_is_br  = is_branch & ~is_jal & ~is_jalr;
  assign w_accept = ex_valid & (r_state == S_IDLE) & (is_branch | is_jal | is_jalr);

  always_comb begin
    w_cond       = 1'b0;
    w_f3_illegal = 1'b0;
    case (funct3)
      3'b000:  w_cond = zf;
      3'b001:  w_cond = ~zf;
      3'b100:  w_cond = sf ^ vf;
      3'b101:  w_cond = ~(sf ^ vf);
      3'b110:  w_cond = ~cf;
      3'b111:  w_cond = cf;
      default: w_f3_illegal = 1'b1;
    endcase
  end

  assign w_taken    = is_jalr | w_is_jal | (w_is_br & w_cond);
  assign w_target   = is_jalr ? (alu_result & C_JALR_MASK) : (pc + imm);
  assign w_aligned  = (w_target[1:0] == 2'b00);
  assign w_redirect = w_accept & w_taken & w_aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = C_CNT_INIT;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect    <= 1'b0;
      r_misalign    <= 1'b0;
      r_illegal     <= 1'b0;
      r_redirect_pc <= '0;
      r_link        <= '0;
    end else begin
      r_redirect <= w_redirect;
      r_misalign <= w_accept & w_taken & ~w_aligned;
      r_illegal  <= w_accept & w_is_br & w_f3_illegal;
      if (w_redirect)
        r_redirect_pc <= w_target;
      // Link is written even when the jump target turns out misaligned.
      if (w_accept & (is_jalr | w_is_jal))
        r_link <= pc + C_LINK_OFS;
    end
  end

  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;
  assign link_o        = r_link;
  assign flush_o       = (r_state == S_FLUSH);
  assign misalign_o    = r_misalign;
  assign illegal_o     = r_illegal;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count, r_br_taken;
  logic        w_br_legal;

  assign w_br_legal = w_accept & w_is_br & ~w_f3_illegal;

  // Saturating counters; a misaligned taken branch still counts as taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count <= 32'd0;
      r_br_taken <= 32'd0;
    end else if (w_br_legal) begin
      if (r_br_count != 32'hFFFF_FFFF)
        r_br_count <= r_br_count + 32'd1;
      if (w_cond && (r_br_taken != 32'hFFFF_FFFF))
        r_br_taken <= r_br_taken + 32'd1;
    end
  end

  assign br_count_o = r_br_count;
  assign br_taken_o = r_br_taken;
`else
  assign br_count_o = 32'd0;
  assign br_taken_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_unit
// Brief   : Self-checking bench for branch_resolve_unit (table vectors plus
//           flush/back-to-back/reset/statistics sequences).
// Revision: 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        cf, zf, vf, sf;
  logic [31:0] pc, imm, alu_result;
  logic        redirect_o, flush_o, misalign_o, illegal_o;
  logic [31:0] redirect_pc_o, link_o, br_count_o, br_taken_o;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit #(.N(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3), .cf(cf), .zf(zf),
    .vf(vf), .sf(sf), .pc(pc), .imm(imm), .alu_result(alu_result),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .link_o(link_o),
    .flush_o(flush_o), .misalign_o(misalign_o), .illegal_o(illegal_o),
    .br_count_o(br_count_o), .br_taken_o(br_taken_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v, br, jal, jalr;
    logic [2:0]  f3;
    logic        cf, zf, vf, sf;
    logic [31:0] pc, imm, alu;
    logic        e_redir;
    logic [31:0] e_rpc, e_link;
    logic        e_mis, e_ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, br, jal, jalr, input logic [2:0] f3,
                              input logic c, z, o, s, input logic [31:0] p, i, a,
                              input logic er, input logic [31:0] erpc, elink,
                              input logic em, ei);
    vec_t t;
    t.v = v; t.br = br; t.jal = jal; t.jalr = jalr; t.f3 = f3;
    t.cf = c; t.zf = z; t.vf = o; t.sf = s; t.pc = p; t.imm = i; t.alu = a;
    t.e_redir = er; t.e_rpc = erpc; t.e_link = elink; t.e_mis = em; t.e_ill = ei;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ex_valid = t.v; is_branch = t.br; is_jal = t.jal; is_jalr = t.jalr;
    funct3 = t.f3; cf = t.cf; zf = t.zf; vf = t.vf; sf = t.sf;
    pc = t.pc; imm = t.imm; alu_result = t.alu;
  endtask

  task automatic idle();
    ex_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = 3'b000; cf = 1'b0; zf = 1'b0; vf = 1'b0; sf = 1'b0;
    pc = 32'h0; imm = 32'h0; alu_result = 32'h0;
  endtask

  int ill_seen;

  // One BNE/illegal branch per call; waits out any flush before returning.
  task automatic send_br(input logic [2:0] f3, input logic z);
    @(negedge clk);
    drive(mk(1, 1, 0, 0, f3, 0, z, 0, 0, 32'h100, 32'h10, 32'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    idle();
    if (illegal_o) ill_seen++;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    //        v br jl jr f3     cf zf vf sf pc          imm          alu         red rpc         link        mis ill
    vecs[0]  = mk(1,1,0,0,3'b000,0,1,0,0,32'h100,  32'h20,      32'h0,     1, 32'h120,  32'h0,   0,0); // BEQ taken
    vecs[1]  = mk(1,1,0,0,3'b110,1,0,0,0,32'h200,  32'h40,      32'h0,     0, 32'h120,  32'h0,   0,0); // BLTU cf=1
    vecs[2]  = mk(1,1,0,0,3'b110,0,0,0,0,32'h200,  32'h40,      32'h0,     1, 32'h240,  32'h0,   0,0); // BLTU cf=0
    vecs[3]  = mk(1,1,0,0,3'b101,0,0,1,1,32'h300,  32'hFFFFFFF0,32'h0,     1, 32'h2F0,  32'h0,   0,0); // BGE sf=vf=1
    vecs[4]  = mk(1,1,0,0,3'b001,0,1,0,0,32'h400,  32'h8,       32'h0,     0, 32'h2F0,  32'h0,   0,0); // BNE zf=1
    vecs[5]  = mk(1,1,0,0,3'b100,0,0,0,1,32'h1000, 32'h8,       32'h0,     1, 32'h1008, 32'h0,   0,0); // BLT
    vecs[6]  = mk(1,1,0,0,3'b111,1,0,0,0,32'h10,   32'h10,      32'h0,     1, 32'h20,   32'h0,   0,0); // BGEU cf=1
    vecs[7]  = mk(1,0,0,1,3'b000,0,0,0,0,32'h40,   32'h0,       32'h205,   1, 32'h204,  32'h44,  0,0); // JALR
    vecs[8]  = mk(1,0,0,1,3'b000,0,0,0,0,32'h80,   32'h0,       32'h206,   0, 32'h204,  32'h84,  1,0); // JALR misaligned
    vecs[9]  = mk(1,0,1,0,3'b000,0,0,0,0,32'h500,  32'h100,     32'h0,     1, 32'h600,  32'h504, 0,0); // JAL
    vecs[10] = mk(1,1,0,0,3'b010,0,1,0,0,32'h600,  32'h4,       32'h0,     0, 32'h600,  32'h504, 0,1); // illegal f3
    vecs[11] = mk(1,1,1,0,3'b000,0,0,0,0,32'h700,  32'h10,      32'h0,     1, 32'h710,  32'h704, 0,0); // JAL beats branch
    vecs[12] = mk(0,1,0,0,3'b000,0,1,0,0,32'h900,  32'h4,       32'h0,     0, 32'h710,  32'h704, 0,0); // not valid
    vecs[13] = mk(1,1,0,0,3'b000,0,1,0,0,32'h100,  32'h2,       32'h0,     0, 32'h710,  32'h704, 1,0); // BEQ misaligned

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_redirect", {31'b0, redirect_o}, 32'h0);
    check("rst_rpc", redirect_pc_o, 32'h0);
    check("rst_link", link_o, 32'h0);
    check("rst_flush", {31'b0, flush_o}, 32'h0);
    check("rst_misalign", {31'b0, misalign_o}, 32'h0);
    check("rst_illegal", {31'b0, illegal_o}, 32'h0);
    check("rst_br_count", br_count_o, 32'h0);
    check("rst_br_taken", br_taken_o, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(negedge clk);
      idle();
      check($sformatf("v%0d_redirect", i), {31'b0, redirect_o}, {31'b0, vecs[i].e_redir});
      check($sformatf("v%0d_rpc", i), redirect_pc_o, vecs[i].e_rpc);
      check($sformatf("v%0d_link", i), link_o, vecs[i].e_link);
      check($sformatf("v%0d_flush1", i), {31'b0, flush_o}, {31'b0, vecs[i].e_redir});
      check($sformatf("v%0d_misalign", i), {31'b0, misalign_o}, {31'b0, vecs[i].e_mis});
      check($sformatf("v%0d_illegal", i), {31'b0, illegal_o}, {31'b0, vecs[i].e_ill});
      @(negedge clk);
      check($sformatf("v%0d_flush2", i), {31'b0, flush_o}, {31'b0, vecs[i].e_redir});
      check($sformatf("v%0d_pulse_end", i), {29'b0, redirect_o, misalign_o, illegal_o}, 32'h0);
      @(negedge clk);
      check($sformatf("v%0d_flush3", i), {31'b0, flush_o}, 32'h0);
    end

    // Taken BEQ held valid through the flush: ignored until the first IDLE cycle.
    @(negedge clk);
    drive(mk(1,1,0,0,3'b000,0,1,0,0,32'h100,32'h20,32'h0,0,0,0,0,0));
    @(negedge clk);
    check("b2b_redirect1", {31'b0, redirect_o}, 32'h1);
    check("b2b_rpc1", redirect_pc_o, 32'h120);
    drive(mk(1,1,0,0,3'b000,0,1,0,0,32'h800,32'h8,32'h0,0,0,0,0,0));
    @(negedge clk);
    check("b2b_squash_redirect", {31'b0, redirect_o}, 32'h0);
    check("b2b_squash_rpc", redirect_pc_o, 32'h120);
    check("b2b_flush", {31'b0, flush_o}, 32'h1);
    @(negedge clk);
    check("b2b_idle_flush", {31'b0, flush_o}, 32'h0);
    check("b2b_idle_redirect", {31'b0, redirect_o}, 32'h0);
    @(negedge clk);
    idle();
    check("b2b_redirect2", {31'b0, redirect_o}, 32'h1);
    check("b2b_rpc2", redirect_pc_o, 32'h808);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the first flush cycle.
    drive(mk(1,0,1,0,3'b000,0,0,0,0,32'h40,32'h40,32'h0,0,0,0,0,0));
    @(negedge clk);
    idle();
    check("ar_redirect_pre", {31'b0, redirect_o}, 32'h1);
    check("ar_flush_pre", {31'b0, flush_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_outputs", {26'b0, redirect_o, flush_o, misalign_o, illegal_o, 2'b0}, 32'h0);
    check("ar_rpc", redirect_pc_o, 32'h0);
    check("ar_link", link_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_idle_flush", {31'b0, flush_o}, 32'h0);
    check("ar_idle_redirect", {31'b0, redirect_o}, 32'h0);

    // Statistics: 3 taken + 2 not-taken BNE + 1 illegal funct3.
    ill_seen = 0;
    send_br(3'b001, 1'b0);
    send_br(3'b001, 1'b1);
    send_br(3'b001, 1'b0);
    send_br(3'b010, 1'b0);
    send_br(3'b001, 1'b1);
    send_br(3'b001, 1'b0);
    check("st_illegal_pulses", ill_seen, 32'd1);
`ifdef BRANCH_STATS_EN
    check("st_br_count", br_count_o, 32'd5);
    check("st_br_taken", br_taken_o, 32'd3);
`else
    check("st_br_count", br_count_o, 32'd0);
    check("st_br_taken", br_taken_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
